// File: rtl/fetch_ctrl_if.sv
// Fetch controller bundle: instruction-memory return data, decode handshake and
// status. The master side is the fetch controller.
interface fetch_ctrl_if #(
    parameter int unsigned PC_W = 16
);
    logic [3:0]      one;
    logic [3:0]      two;
    logic [3:0]      three;
    logic [3:0]      four;
    logic            stall;
    logic            br_taken;
    logic [PC_W-1:0] br_target;
    logic [PC_W-1:0] pc;
    logic [15:0]     inst;
    logic [PC_W-1:0] inst_pc;
    logic            inst_valid;
    logic            halted;
    logic            fault;

    modport master (
        input  one, two, three, four, stall, br_taken, br_target,
        output pc, inst, inst_pc, inst_valid, halted, fault
    );

    modport slave (
        output one, two, three, four, stall, br_taken, br_target,
        input  pc, inst, inst_pc, inst_valid, halted, fault
    );
endinterface

// File: rtl/fetch_ctrl.sv
// PC sequencer / fetch controller in front of a one-cycle registered instruction
// memory: sequential issue, branch squash, stall hold, halt and range fault.
module fetch_ctrl #(
    parameter int unsigned      PC_W     = 16,
    parameter logic [PC_W-1:0]  RESET_PC = '0,
    parameter int unsigned      PC_STEP  = 2,
    parameter int unsigned      MEM_LAST = 10,
    parameter logic [3:0]       HALT_OP  = 4'hF
) (
    input  logic          clk,
    input  logic          rst,
    fetch_ctrl_if.master  bus
);
    localparam int unsigned CMP_W = PC_W + 1;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    state_e          state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] ipc_q;
    logic            v_q;
    logic            hold_v_q;
    logic [15:0]     hold_inst_q;
    logic            halted_q;
    logic            fault_q;

    logic [15:0]     mem_word;
    logic [15:0]     inst_c;
    logic            run;
    logic            inst_valid_c;
    logic            issue;
    logic            accept;
    logic            out_of_range;
    logic            halt_op;

    // Presented instruction and per-edge decisions
    always_comb begin
        mem_word     = {bus.one, bus.two, bus.three, bus.four};
        run          = (state_q == RUN);
        inst_c       = hold_v_q ? hold_inst_q : mem_word;
        inst_valid_c = (hold_v_q | v_q) & run;
        issue        = run & ~bus.br_taken & ~bus.stall;
        accept       = inst_valid_c & issue;
        // Widened compare so the top address (pc+1 wrapping) still faults
        out_of_range = (CMP_W'(pc_q) + CMP_W'(1)) > CMP_W'(MEM_LAST);
        halt_op      = (inst_c[15:12] == HALT_OP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            ipc_q       <= '0;
            v_q         <= 1'b0;
            hold_v_q    <= 1'b0;
            hold_inst_q <= '0;
            halted_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else if (state_q == RUN) begin
            if (bus.br_taken) begin
                hold_v_q <= 1'b0;
                v_q      <= 1'b0;
                pc_q     <= bus.br_target;
            end else if (bus.stall) begin
                v_q <= 1'b0;
                if (inst_valid_c) begin
                    hold_inst_q <= inst_c;
                    hold_v_q    <= 1'b1;
                end
            end else if (out_of_range) begin
                v_q      <= 1'b0;
                hold_v_q <= 1'b0;
                state_q  <= HALT;
                halted_q <= 1'b1;
                fault_q  <= 1'b1;
            end else if (accept && halt_op) begin
                // Halt instruction is delivered this cycle; nothing further issues
                v_q      <= 1'b0;
                hold_v_q <= 1'b0;
                state_q  <= HALT;
                halted_q <= 1'b1;
            end else begin
                hold_v_q <= 1'b0;
                v_q      <= 1'b1;
                ipc_q    <= pc_q;
                pc_q     <= pc_q + PC_W'(PC_STEP);
            end
        end
    end

    assign bus.pc         = pc_q;
    assign bus.inst       = inst_c;
    assign bus.inst_pc    = ipc_q;
    assign bus.inst_valid = inst_valid_c;
    assign bus.halted     = halted_q;
    assign bus.fault      = fault_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, hand-written corner sequences and
// randomized stall/branch traffic against a transaction-level reference model.
module tb_fetch_ctrl;
    localparam int unsigned PC_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fetch_ctrl_if #(.PC_W(PC_W)) bus_a ();
    fetch_ctrl_if #(.PC_W(PC_W)) bus_b ();

    fetch_ctrl #(.PC_W(PC_W)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    fetch_ctrl #(.PC_W(PC_W), .HALT_OP(4'h4)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    always #5 clk = ~clk;

    function automatic logic [7:0] byte_at(input logic [15:0] a);
        case (a)
            16'd0:   return 8'h00;
            16'd1:   return 8'h91;
            16'd2:   return 8'h82;
            16'd3:   return 8'h73;
            16'd4:   return 8'h64;
            16'd5:   return 8'h55;
            16'd6:   return 8'h46;
            16'd7:   return 8'h37;
            16'd8:   return 8'h28;
            16'd9:   return 8'h19;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [15:0] word_at(input logic [15:0] a);
        return {byte_at(a), byte_at(a + 16'd1)};
    endfunction

    // Instruction memories with one-cycle registered read
    always @(posedge clk) begin
        {bus_a.one, bus_a.two}   <= byte_at(bus_a.pc);
        {bus_a.three, bus_a.four} <= byte_at(bus_a.pc + 16'd1);
        {bus_b.one, bus_b.two}   <= byte_at(bus_b.pc);
        {bus_b.three, bus_b.four} <= byte_at(bus_b.pc + 16'd1);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: next fetch address plus the one instruction slot in front of decode
    logic [15:0] m_pc;
    logic [15:0] m_slot;
    bit          m_valid;
    bit          m_halted;
    bit          m_fault;

    function automatic void model_reset();
        m_pc = 16'd0; m_slot = 16'd0; m_valid = 0; m_halted = 0; m_fault = 0;
    endfunction

    function automatic void model_step(input bit s, input bit b, input logic [15:0] t);
        logic [15:0] w;
        if (m_halted) return;
        w = word_at(m_slot);
        if (b) begin
            m_pc = t;
            m_valid = 0;
        end else if (!s) begin
            if (int'(m_pc) + 1 > 10) begin
                m_fault = 1; m_halted = 1; m_valid = 0;
            end else if (m_valid && w[15:12] == 4'hF) begin
                m_halted = 1; m_valid = 0;
            end else begin
                m_slot = m_pc; m_valid = 1; m_pc = m_pc + 16'd2;
            end
        end
    endfunction

    task automatic model_check(input int n);
        chk($sformatf("rnd%0d inst_valid", n), 32'(bus_a.inst_valid), 32'(m_valid));
        chk($sformatf("rnd%0d pc", n), 32'(bus_a.pc), 32'(m_pc));
        chk($sformatf("rnd%0d halted", n), 32'(bus_a.halted), 32'(m_halted));
        chk($sformatf("rnd%0d fault", n), 32'(bus_a.fault), 32'(m_fault));
        if (m_valid) begin
            chk($sformatf("rnd%0d inst", n), 32'(bus_a.inst), 32'(word_at(m_slot)));
            chk($sformatf("rnd%0d inst_pc", n), 32'(bus_a.inst_pc), 32'(m_slot));
        end
    endtask

    // Called at a falling edge; releases reset before the next rising edge
    task automatic do_reset();
        rst = 1'b0;
        bus_a.stall = 1'b0; bus_a.br_taken = 1'b0; bus_a.br_target = '0;
        bus_b.stall = 1'b0; bus_b.br_taken = 1'b0; bus_b.br_target = '0;
        model_reset();
        #2;
        rst = 1'b1;
    endtask

    typedef struct {
        bit          rst_before;
        bit          stall;
        bit          br;
        logic [15:0] tgt;
        bit          e_v;
        logic [15:0] e_inst;
        logic [15:0] e_ipc;
        logic [15:0] e_pc;
        bit          e_halt;
        bit          e_fault;
    } vec_t;

    vec_t vt[$];

    function automatic void mk(bit r, bit s, bit b, logic [15:0] t, bit ev,
                               logic [15:0] ei, logic [15:0] eipc, logic [15:0] epc,
                               bit eh, bit ef);
        vec_t v;
        v.rst_before = r; v.stall = s; v.br = b; v.tgt = t; v.e_v = ev;
        v.e_inst = ei; v.e_ipc = eipc; v.e_pc = epc; v.e_halt = eh; v.e_fault = ef;
        vt.push_back(v);
    endfunction

    initial begin
        bit          found;
        int          seen;
        logic [15:0] pc_frozen;

        bus_a.stall = 1'b0; bus_a.br_taken = 1'b0; bus_a.br_target = '0;
        bus_b.stall = 1'b0; bus_b.br_taken = 1'b0; bus_b.br_target = '0;

        // Free run to the end of memory
        mk(1,0,0,16'h0,     0,16'h0000,16'd0, 16'd0,  0,0);
        mk(0,0,0,16'h0,     1,16'h0091,16'd0, 16'd2,  0,0);
        mk(0,0,0,16'h0,     1,16'h8273,16'd2, 16'd4,  0,0);
        mk(0,0,0,16'h0,     1,16'h6455,16'd4, 16'd6,  0,0);
        mk(0,0,0,16'h0,     1,16'h4637,16'd6, 16'd8,  0,0);
        mk(0,0,0,16'h0,     1,16'h2819,16'd8, 16'd10, 0,0);
        mk(0,0,0,16'h0,     0,16'h0000,16'd0, 16'd10, 1,1);
        mk(0,0,0,16'h0,     0,16'h0000,16'd0, 16'd10, 1,1);
        // Three-cycle stall on 8273@2
        mk(1,0,0,16'h0,     0,16'h0000,16'd0, 16'd0,  0,0);
        mk(0,0,0,16'h0,     1,16'h0091,16'd0, 16'd2,  0,0);
        mk(0,1,0,16'h0,     1,16'h8273,16'd2, 16'd4,  0,0);
        mk(0,1,0,16'h0,     1,16'h8273,16'd2, 16'd4,  0,0);
        mk(0,1,0,16'h0,     1,16'h8273,16'd2, 16'd4,  0,0);
        mk(0,0,0,16'h0,     1,16'h8273,16'd2, 16'd4,  0,0);
        mk(0,0,0,16'h0,     1,16'h6455,16'd4, 16'd6,  0,0);
        mk(0,0,0,16'h0,     1,16'h4637,16'd6, 16'd8,  0,0);
        // Redirect to 8 while 0091@0 is presented
        mk(1,0,0,16'h0,     0,16'h0000,16'd0, 16'd0,  0,0);
        mk(0,0,1,16'd8,     1,16'h0091,16'd0, 16'd2,  0,0);
        mk(0,0,0,16'h0,     0,16'h0000,16'd0, 16'd8,  0,0);
        mk(0,0,0,16'h0,     1,16'h2819,16'd8, 16'd10, 0,0);
        mk(0,0,0,16'h0,     0,16'h0000,16'd0, 16'd10, 1,1);
        // Redirect to the top address
        mk(1,0,0,16'h0,     0,16'h0000,16'd0, 16'd0,  0,0);
        mk(0,0,1,16'hFFFF,  1,16'h0091,16'd0, 16'd2,  0,0);
        mk(0,0,0,16'h0,     0,16'h0000,16'd0, 16'hFFFF,0,0);
        mk(0,0,0,16'h0,     0,16'h0000,16'd0, 16'hFFFF,1,1);

        #2;
        @(negedge clk);
        foreach (vt[i]) begin
            if (vt[i].rst_before) do_reset();
            bus_a.stall = vt[i].stall;
            bus_a.br_taken = vt[i].br;
            bus_a.br_target = vt[i].tgt;
            #1;
            chk($sformatf("vec%0d inst_valid", i), 32'(bus_a.inst_valid), 32'(vt[i].e_v));
            chk($sformatf("vec%0d pc", i), 32'(bus_a.pc), 32'(vt[i].e_pc));
            chk($sformatf("vec%0d halted", i), 32'(bus_a.halted), 32'(vt[i].e_halt));
            chk($sformatf("vec%0d fault", i), 32'(bus_a.fault), 32'(vt[i].e_fault));
            if (vt[i].e_v) begin
                chk($sformatf("vec%0d inst", i), 32'(bus_a.inst), 32'(vt[i].e_inst));
                chk($sformatf("vec%0d inst_pc", i), 32'(bus_a.inst_pc), 32'(vt[i].e_ipc));
            end
            @(negedge clk);
        end

        // Halt opcode 4: 4637@6 is delivered, then the block stops without fault
        do_reset();
        found = 0;
        seen = 0;
        for (int c = 0; c < 12 && !found; c++) begin
            #1;
            if (bus_b.inst_valid) begin
                if (bus_b.inst == 16'h4637) begin
                    found = 1;
                    chk("halt inst_pc", 32'(bus_b.inst_pc), 32'd6);
                end else begin
                    seen++;
                end
            end
            @(negedge clk);
        end
        chk("halt delivered", 32'(found), 32'd1);
        chk("halt preceding count", 32'(seen), 32'd3);
        #1;
        chk("halt halted", 32'(bus_b.halted), 32'd1);
        chk("halt fault", 32'(bus_b.fault), 32'd0);
        chk("halt inst_valid", 32'(bus_b.inst_valid), 32'd0);
        pc_frozen = bus_b.pc;
        bus_b.br_taken = 1'b1;
        bus_b.br_target = 16'd0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("halt frozen pc %0d", c), 32'(bus_b.pc), 32'(pc_frozen));
            chk($sformatf("halt no valid %0d", c), 32'(bus_b.inst_valid), 32'd0);
            chk($sformatf("halt stays %0d", c), 32'(bus_b.halted), 32'd1);
        end
        bus_b.br_taken = 1'b0;
        @(negedge clk);

        // Asynchronous reset between edges while an instruction is held
        do_reset();
        @(negedge clk);
        bus_a.stall = 1'b1;
        @(posedge clk);
        #2;
        chk("async held valid", 32'(bus_a.inst_valid), 32'd1);
        chk("async held inst", 32'(bus_a.inst), 32'h0091);
        rst = 1'b0;
        #1;
        chk("async inst_valid", 32'(bus_a.inst_valid), 32'd0);
        chk("async halted", 32'(bus_a.halted), 32'd0);
        chk("async pc", 32'(bus_a.pc), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        bus_a.stall = 1'b0;
        #1;
        chk("async restart bubble", 32'(bus_a.inst_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("async restart valid", 32'(bus_a.inst_valid), 32'd1);
        chk("async restart inst", 32'(bus_a.inst), 32'h0091);
        chk("async restart inst_pc", 32'(bus_a.inst_pc), 32'd0);
        @(negedge clk);

        // Randomized stall / branch traffic against the reference model
        do_reset();
        for (int n = 0; n < 800; n++) begin
            bit          s;
            bit          b;
            logic [15:0] t;
            if (m_halted && $urandom_range(0, 3) == 0) do_reset();
            s = ($urandom_range(0, 9) < 3);
            b = ($urandom_range(0, 9) == 0);
            t = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 12));
            bus_a.stall = s;
            bus_a.br_taken = b;
            bus_a.br_target = t;
            #1;
            model_check(n);
            @(posedge clk);
            model_step(s, b, t);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
